// File: rtl/cheese_ctl.sv
// Cheese life-cycle controller: requests a spawn position, shows the cheese,
// detects the mouse eating it, keeps score and paces respawns.
module cheese_ctl #(
  parameter int CHEESE_W       = 20,
  parameter int CHEESE_H       = 20,
  parameter int MOUSE_W        = 32,
  parameter int MOUSE_H        = 32,
  parameter int RESPAWN_CYCLES = 65_000_000,
  parameter int SCORE_W        = 8,
  parameter int SCORE_TARGET   = 10,
  parameter int POS_W          = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_en,
  input  logic [POS_W-1:0]   spawn_x,
  input  logic [POS_W-1:0]   spawn_y,
  input  logic [POS_W-1:0]   mouse_x,
  input  logic [POS_W-1:0]   mouse_y,
  output logic               rnd_generate,
  output logic [POS_W-1:0]   cheese_x,
  output logic [POS_W-1:0]   cheese_y,
  output logic               cheese_vis,
  output logic               eaten,
  output logic [SCORE_W-1:0] score,
  output logic               win
);

  localparam int CNT_W = (RESPAWN_CYCLES > 0) ? $clog2(RESPAWN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]   RESP_LD = CNT_W'(RESPAWN_CYCLES);
  localparam logic [POS_W:0]     CW      = (POS_W+1)'(CHEESE_W);
  localparam logic [POS_W:0]     CH      = (POS_W+1)'(CHEESE_H);
  localparam logic [POS_W:0]     MW      = (POS_W+1)'(MOUSE_W);
  localparam logic [POS_W:0]     MH      = (POS_W+1)'(MOUSE_H);
  localparam logic [SCORE_W:0]   TGT     = (SCORE_W+1)'(SCORE_TARGET);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, ACTIVE, RESPAWN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               overlap, score_hit;
  logic [SCORE_W-1:0] score_inc;
  logic [POS_W:0]     mx, my, cx, cy;

  logic               rnd_nxt, vis_nxt, eaten_nxt, win_nxt;
  logic [POS_W-1:0]   cx_nxt, cy_nxt;
  logic [SCORE_W-1:0] score_nxt;

  // One extra bit keeps the box sums from wrapping at the screen edge.
  assign mx = {1'b0, mouse_x};
  assign my = {1'b0, mouse_y};
  assign cx = {1'b0, cheese_x};
  assign cy = {1'b0, cheese_y};
  assign overlap = (mx < cx + CW) && (cx < mx + MW) &&
                   (my < cy + CH) && (cy < my + MH);

  assign score_inc = (score == '1) ? score : score + 1'b1;
  assign score_hit = {1'b0, score_inc} >= TGT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rnd_generate <= 1'b0;
      cheese_x     <= '0;
      cheese_y     <= '0;
      cheese_vis   <= 1'b0;
      eaten        <= 1'b0;
      score        <= '0;
      win          <= 1'b0;
    end else if (game_en) begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rnd_generate <= rnd_nxt;
      cheese_x     <= cx_nxt;
      cheese_y     <= cy_nxt;
      cheese_vis   <= vis_nxt;
      eaten        <= eaten_nxt;
      score        <= score_nxt;
      win          <= win_nxt;
    end else begin
      rnd_generate <= 1'b0;
      eaten        <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     state_nxt = LOAD;
      LOAD:    state_nxt = ACTIVE;
      ACTIVE:  if (overlap) begin
                 if (score_hit) state_nxt = DONE;
                 else begin
                   state_nxt = RESPAWN;
                   cnt_nxt   = RESP_LD;
                 end
               end
      RESPAWN: if (cnt == '0) state_nxt = REQ;
               else cnt_nxt = cnt - 1'b1;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition.
  always_comb begin
    rnd_nxt   = (state_nxt == REQ);
    vis_nxt   = (state_nxt == ACTIVE);
    eaten_nxt = (state == ACTIVE) && overlap;
    cx_nxt    = (state == LOAD) ? spawn_x : cheese_x;
    cy_nxt    = (state == LOAD) ? spawn_y : cheese_y;
    score_nxt = eaten_nxt ? score_inc : score;
    win_nxt   = win | (state_nxt == DONE);
  end

endmodule
